// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter for a shared external 4:1 mux.
// It picks one of four requesters and drives the mux select. It then
// registers the mux output into a one-entry valid/ready output stage.
// Optional build macro: ARB_FIXED_PRIO_EN. When it is defined, the arbiter
// uses fixed priority, with requester 0 highest.
module mux4_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] mux_out,
  output logic [1:0]        sel,
  output logic [3:0]        gnt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_reg;
  logic [1:0]        ptr_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic       any_req;
  logic       can_cap;
  logic       cap;
  logic [1:0] winner;
  logic [1:0] cand [4];
  logic [3:0] hit;

  assign any_req = |req;
  // The output slot can take new data when it is empty, or when its
  // current contents leave on this same edge.
  assign can_cap = (state_reg == EMPTY) | out_ready;
  assign cap     = can_cap & any_req;

  // Search order starts just after the last winner: ptr+1, ptr+2, ptr+3, ptr.
  // The last candidate wraps back to ptr itself, so a lone requester can win
  // again on every cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = ptr_reg + 2'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Pick the first requesting candidate in search order. The default keeps
  // the select stable when nobody is requesting.
  always_comb begin
    winner = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) winner = cand[i];
    end
  end

  // With no requests, sel holds a defined value so that it never goes to X.
`ifdef ARB_FIXED_PRIO_EN
  assign sel = any_req ? winner : 2'd0;
`else
  assign sel = any_req ? winner : ptr_reg;
`endif

  // A grant is asserted only when the capture really happens on this edge.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gnt
      assign gnt[gi] = cap & (winner == 2'(gi));
    end
  endgenerate

  assign out_valid = (state_reg == FULL);
  assign out_data  = out_data_reg;

  // Output stage and arbitration pointer. A capture takes priority over a
  // plain drain, so back-to-back transfers do not leave a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      out_data_reg <= '0;
      ptr_reg      <= 2'd3;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (cap) begin
            out_data_reg <= mux_out;
            state_reg    <= FULL;
`ifdef ARB_FIXED_PRIO_EN
            ptr_reg      <= 2'd3;
`else
            ptr_reg      <= winner;
`endif
          end
        end
        FULL: begin
          if (cap) begin
            out_data_reg <= mux_out;
            state_reg    <= FULL;
`ifdef ARB_FIXED_PRIO_EN
            ptr_reg      <= 2'd3;
`else
            ptr_reg      <= winner;
`endif
          end else if (out_ready) begin
            state_reg <= EMPTY;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule
